// File: rtl/serial_word_receiver.sv
// serial_word_receiver
// Collects a framed serial bit stream into a WIDTH-bit word and hands it to a
// consumer through a valid/ready holding register. A frame opens with a
// start strobe; each bit_valid strobe then carries one bit of Ser_In. The
// first bit received ends up at Par_Out[WIDTH-1], the last at Par_Out[0],
// matching a transmitter that shifts out index WIDTH-1 first.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame open; bit strobes are ignored until start
// RECV  | frame open; collecting bits, bit_cnt = bits accepted so far

module serial_word_receiver #(
    parameter  int WIDTH = 24,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Ser_In,
    input  logic             bit_valid,
    input  logic             start,
    input  logic             clear_err,
    input  logic             word_ready,
    output logic [0:WIDTH-1] Par_Out,
    output logic             word_valid,
    output logic             busy,
    output logic             frame_abort,
    output logic             overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [0:WIDTH-1] shreg;

    logic             accept_bit;
    logic             word_done;
    logic [0:WIDTH-1] next_shreg;

    // A bit is taken only inside an open frame and never alongside a start,
    // which always wins. The completing word includes the bit being sampled.
    always_comb begin
        accept_bit = 1'b0;
        word_done  = 1'b0;
        next_shreg = {Ser_In, shreg[0:WIDTH-2]};
        if (state == RECV && !start && bit_valid) begin
            accept_bit = 1'b1;
            word_done  = (bit_cnt == LAST_BIT);
        end
    end

    // Frame sequencing: state, bit counter, shift register, busy and abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            busy        <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RECV;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                RECV: begin
                    if (start) begin
                        // Restart only flags an abort if partial data is lost.
                        bit_cnt     <= '0;
                        frame_abort <= (bit_cnt != '0);
                    end else if (accept_bit) begin
                        shreg <= next_shreg;
                        if (word_done) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register: load, hand off, drop-on-full and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Par_Out    <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (word_done) begin
                if (!word_valid || word_ready) begin
                    Par_Out    <= next_shreg;
                    word_valid <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            // A new drop on the same cycle as clear_err keeps the flag set.
            if (word_done && word_valid && !word_ready) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver at WIDTH=24 and WIDTH=80.
module tb_serial_word_receiver;

    logic        clk;
    logic        rst;

    logic        ser_in, bit_valid, start, clear_err, word_ready;
    logic [0:23] par_out;
    logic        word_valid, busy, frame_abort, overrun;

    logic        b_ser_in, b_bit_valid, b_start, b_clear_err, b_word_ready;
    logic [0:79] b_par_out;
    logic        b_word_valid, b_busy, b_frame_abort, b_overrun;

    int checks = 0;
    int errors = 0;

    serial_word_receiver #(.WIDTH(24)) dut24 (
        .clk         (clk),
        .rst         (rst),
        .Ser_In      (ser_in),
        .bit_valid   (bit_valid),
        .start       (start),
        .clear_err   (clear_err),
        .word_ready  (word_ready),
        .Par_Out     (par_out),
        .word_valid  (word_valid),
        .busy        (busy),
        .frame_abort (frame_abort),
        .overrun     (overrun)
    );

    serial_word_receiver #(.WIDTH(80)) dut80 (
        .clk         (clk),
        .rst         (rst),
        .Ser_In      (b_ser_in),
        .bit_valid   (b_bit_valid),
        .start       (b_start),
        .clear_err   (b_clear_err),
        .word_ready  (b_word_ready),
        .Par_Out     (b_par_out),
        .word_valid  (b_word_valid),
        .busy        (b_busy),
        .frame_abort (b_frame_abort),
        .overrun     (b_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        ser_in    = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    // Sends w[23] first down to w[0]; optional gaps and last-bit side strobes.
    task automatic send_word(input logic [0:23] w, input bit gaps,
                             input bit rdy_last, input bit clr_last);
        for (int i = 23; i >= 0; i--) begin
            ser_in    = w[i];
            bit_valid = 1'b1;
            if (i == 0) begin
                word_ready = rdy_last;
                clear_err  = clr_last;
            end
            @(negedge clk);
            bit_valid  = 1'b0;
            word_ready = 1'b0;
            clear_err  = 1'b0;
            if (gaps && i != 0) @(negedge clk);
        end
    endtask

    task automatic consume();
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
    endtask

    initial begin
        logic [0:23] w;
        logic [0:79] wb;

        rst = 1'b1;
        ser_in = 0; bit_valid = 0; start = 0; clear_err = 0; word_ready = 0;
        b_ser_in = 0; b_bit_valid = 0; b_start = 0; b_clear_err = 0; b_word_ready = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_par_out", 80'(par_out), 80'h0);
        check("rst_flags", {76'h0, word_valid, busy, frame_abort, overrun}, 80'h0);

        // 1: back-to-back frame, latency boundary, then hand-off
        w = 24'hA5C3F0;
        send_start();
        check("s1_busy_after_start", 80'(busy), 80'h1);
        for (int i = 23; i >= 1; i--) send_bit(w[i]);
        check("s1_no_valid_before_last", {78'h0, word_valid, busy}, 80'h1);
        send_bit(w[0]);
        check("s1_par_out", 80'(par_out), 80'hA5C3F0);
        check("s1_valid_busy", {78'h0, word_valid, busy}, 80'h2);
        consume();
        check("s1_consumed", 80'(word_valid), 80'h0);
        check("s1_par_out_kept", 80'(par_out), 80'hA5C3F0);

        // 2: pre-start bits ignored, start+bit together, gapped bits
        send_bit(1'b1);
        send_bit(1'b0);
        check("s2_idle_ignores_bits", {78'h0, busy, word_valid}, 80'h0);
        start = 1'b1; bit_valid = 1'b1; ser_in = 1'b1;
        @(negedge clk);
        start = 1'b0; bit_valid = 1'b0;
        send_word(24'h123456, 1'b1, 1'b0, 1'b0);
        check("s2_par_out", 80'(par_out), 80'h123456);
        check("s2_valid", 80'(word_valid), 80'h1);
        consume();

        // 3: restart with and without partial data
        send_start();
        check("s3_no_abort_from_idle", 80'(frame_abort), 80'h0);
        send_start();
        check("s3_no_abort_empty", 80'(frame_abort), 80'h0);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        send_start();
        check("s3_abort_pulse", {78'h0, frame_abort, busy}, 80'h3);
        @(negedge clk);
        check("s3_abort_one_cycle", 80'(frame_abort), 80'h0);
        send_word(24'h00FFFF, 1'b0, 1'b0, 1'b0);
        check("s3_par_out", 80'(par_out), 80'h00FFFF);
        consume();

        // 4: overrun, clear, and set winning over clear
        send_start();
        send_word(24'h111111, 1'b0, 1'b0, 1'b0);
        send_start();
        send_word(24'h222222, 1'b0, 1'b0, 1'b0);
        check("s4_par_out_kept", 80'(par_out), 80'h111111);
        check("s4_overrun", {78'h0, word_valid, overrun}, 80'h3);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("s4_cleared", 80'(overrun), 80'h0);
        send_start();
        send_word(24'h555555, 1'b0, 1'b0, 1'b1);
        check("s4_set_wins", 80'(overrun), 80'h1);
        check("s4_par_out_still", 80'(par_out), 80'h111111);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        consume();
        check("s4_final", {78'h0, word_valid, overrun}, 80'h0);

        // 5: simultaneous hand-off with completion
        send_start();
        send_word(24'h111111, 1'b0, 1'b0, 1'b0);
        send_start();
        send_word(24'h333333, 1'b0, 1'b1, 1'b0);
        check("s5_par_out", 80'(par_out), 80'h333333);
        check("s5_valid_no_overrun", {78'h0, word_valid, overrun}, 80'h2);
        consume();

        // 6: async reset mid-frame, then a clean frame
        send_start();
        for (int i = 0; i < 12; i++) send_bit(1'b1);
        rst = 1'b1;
        #1;
        check("s6_rst_par_out", 80'(par_out), 80'h0);
        check("s6_rst_flags", {76'h0, word_valid, busy, frame_abort, overrun}, 80'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("s6_no_abort_after_rst", 80'(frame_abort), 80'h0);
        send_start();
        send_word(24'hFEDCBA, 1'b0, 1'b0, 1'b0);
        check("s6_par_out", 80'(par_out), 80'hFEDCBA);
        check("s6_valid", 80'(word_valid), 80'h1);

        // 80-bit build: same back-to-back frame
        wb = {10{8'hF0}};
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 79; i >= 0; i--) begin
            b_ser_in    = wb[i];
            b_bit_valid = 1'b1;
            @(negedge clk);
            b_bit_valid = 1'b0;
            if (i == 1) check("w80_no_valid_before_last", {78'h0, b_word_valid, b_busy}, 80'h1);
        end
        check("w80_par_out", 80'(b_par_out), {10{8'hF0}});
        check("w80_valid_busy", {78'h0, b_word_valid, b_busy}, 80'h2);
        b_word_ready = 1'b1;
        @(negedge clk);
        b_word_ready = 1'b0;
        check("w80_consumed", 80'(b_word_valid), 80'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
